// File: rtl/sound_player.sv
// Game sound sequencer: plays a short per-code note sequence as a square wave on pwm.
// Optional feature macro SOUND_VOLUME_EN adds a volume port and an 8-bit duty carrier.
module sound_player #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NOTE_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] sound_code,
  input  logic       play_sound,
`ifdef SOUND_VOLUME_EN
  input  logic [1:0] volume,
`endif
  output logic       pwm,
  output logic       busy
);

  localparam int MAX_SLOT = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CNT_W    = $clog2(MAX_SLOT + 1);
  localparam int HALF_W   = $clog2(CLK_HZ / (2 * 262) + 1);

  localparam logic [HALF_W-1:0] H220  = HALF_W'(CLK_HZ / (2 * 220));
  localparam logic [HALF_W-1:0] H262  = HALF_W'(CLK_HZ / (2 * 262));
  localparam logic [HALF_W-1:0] H330  = HALF_W'(CLK_HZ / (2 * 330));
  localparam logic [HALF_W-1:0] H392  = HALF_W'(CLK_HZ / (2 * 392));
  localparam logic [HALF_W-1:0] H523  = HALF_W'(CLK_HZ / (2 * 523));
  localparam logic [HALF_W-1:0] H659  = HALF_W'(CLK_HZ / (2 * 659));
  localparam logic [HALF_W-1:0] H784  = HALF_W'(CLK_HZ / (2 * 784));
  localparam logic [HALF_W-1:0] H1047 = HALF_W'(CLK_HZ / (2 * 1047));

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        code_q, code_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0] hcnt_q, hcnt_d;
  logic              phase_q, phase_d;
  logic              pwm_q, pwm_d;
  logic              busy_q, busy_d;
  logic [HALF_W-1:0] half_s;
  logic              last_s;
  logic              start_s;

`ifdef SOUND_VOLUME_EN
  logic [7:0] car_q, car_d;
  logic [8:0] duty_s;
`endif

  assign start_s = play_sound && (sound_code != 3'd0);

  // Note ROM: half-period and last-note flag for the current code and note slot
  always_comb begin
    half_s = H523;
    last_s = 1'b1;
    case ({code_q, idx_q})
      5'b001_00: begin half_s = H523;  last_s = 1'b1; end
      5'b010_00: begin half_s = H659;  last_s = 1'b1; end
      5'b011_00: begin half_s = H784;  last_s = 1'b0; end
      5'b011_01: begin half_s = H523;  last_s = 1'b1; end
      5'b100_00: begin half_s = H220;  last_s = 1'b0; end
      5'b100_01: begin half_s = H220;  last_s = 1'b1; end
      5'b101_00: begin half_s = H659;  last_s = 1'b0; end
      5'b101_01: begin half_s = H784;  last_s = 1'b1; end
      5'b110_00: begin half_s = H523;  last_s = 1'b0; end
      5'b110_01: begin half_s = H659;  last_s = 1'b0; end
      5'b110_10: begin half_s = H784;  last_s = 1'b0; end
      5'b110_11: begin half_s = H1047; last_s = 1'b1; end
      5'b111_00: begin half_s = H392;  last_s = 1'b0; end
      5'b111_01: begin half_s = H330;  last_s = 1'b0; end
      5'b111_10: begin half_s = H262;  last_s = 1'b1; end
      default:   begin half_s = H523;  last_s = 1'b1; end
    endcase
  end

  // Next-state: a nonzero trigger restarts from note 0 in any state
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    if (start_s) begin
      state_d = NOTE;
      code_d  = sound_code;
      idx_d   = 2'd0;
      cnt_d   = '0;
      hcnt_d  = '0;
      phase_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        NOTE: begin
          if (hcnt_q == half_s - HALF_W'(1)) begin
            hcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            hcnt_d  = hcnt_q + HALF_W'(1);
          end
          if (cnt_q == NOTE_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
            hcnt_d  = '0;
            phase_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (last_s) begin
              state_d = IDLE;
              code_d  = 3'd0;
              idx_d   = 2'd0;
            end else begin
              state_d = NOTE;
              idx_d   = idx_q + 2'd1;
              hcnt_d  = '0;
              phase_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          code_d  = 3'd0;
          idx_d   = 2'd0;
          cnt_d   = '0;
          hcnt_d  = '0;
          phase_d = 1'b0;
        end
      endcase
    end
  end

`ifdef SOUND_VOLUME_EN
  assign car_d = car_q + 8'd1;

  // Output decode, with the tone gated by the volume duty carrier
  always_comb begin
    case (volume)
      2'd0:    duty_s = 9'd0;
      2'd1:    duty_s = 9'd64;
      2'd2:    duty_s = 9'd128;
      2'd3:    duty_s = 9'd256;
      default: duty_s = 9'd256;
    endcase
    busy_d = (state_d != IDLE);
    if (state_d == NOTE) begin
      pwm_d = phase_d && ({1'b0, car_d} < duty_s);
    end else begin
      pwm_d = 1'b0;
    end
  end
`else
  // Output decode from next-state so the registered outputs show t+1 latency
  always_comb begin
    busy_d = (state_d != IDLE);
    if (state_d == NOTE) begin
      pwm_d = phase_d;
    end else begin
      pwm_d = 1'b0;
    end
  end
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      phase_q <= 1'b0;
      pwm_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SOUND_VOLUME_EN
      car_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
      busy_q  <= busy_d;
`ifdef SOUND_VOLUME_EN
      car_q   <= car_d;
`endif
    end
  end

  assign pwm  = pwm_q;
  assign busy = busy_q;

endmodule
